// File: rtl/dlsc_pcie_tx_arbiter.sv
// rtl/dlsc_pcie_tx_arbiter.sv - packet round-robin arbiter for a shared PCIe TX beat stream (optional DLSC_PCIE_ARB_MAXLEN_EN)
module dlsc_pcie_tx_arbiter #(
    parameter int INPUTS    = 4,
    parameter int DATA      = 32,
    parameter int IDB       = 2,
    parameter int MAX_BEATS = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INPUTS*DATA-1:0]   in_data,
    input  logic [INPUTS-1:0]        in_last,
    input  logic [INPUTS-1:0]        in_valid,
    output logic [INPUTS-1:0]        in_ready,
    output logic [DATA-1:0]          out_data,
    output logic                     out_last,
    output logic [IDB-1:0]           out_id,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_trunc
);

    localparam int PW = $clog2(INPUTS);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [DATA-1:0] out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [IDB-1:0]  out_id_q, out_id_d;
    logic            out_valid_q, out_valid_d;

    logic            slot_free;
    logic            accept;
    logic            beat_last;
    logic [PW-1:0]   ptr_inc;
    logic            scan_hit;
    logic [PW-1:0]   scan_idx;
    logic [PW:0]     cand;

    // Round-robin scan: first valid input at or after ptr, wrapping.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int k = 0; k < INPUTS; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(INPUTS)) begin
                cand = cand - (PW+1)'(INPUTS);
            end
            if (!scan_hit && in_valid[cand[PW-1:0]]) begin
                scan_hit = 1'b1;
                scan_idx = cand[PW-1:0];
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign accept    = (state_q == ST_BUSY) && in_valid[grant_q] && slot_free;
    assign ptr_inc   = (grant_q == PW'(INPUTS-1)) ? '0 : grant_q + PW'(1);

    always_comb begin
        in_ready = '0;
        if (state_q == ST_BUSY) begin
            in_ready[grant_q] = slot_free;
        end
    end

`ifdef DLSC_PCIE_ARB_MAXLEN_EN
    localparam int CW = $clog2(MAX_BEATS+1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          trunc;

    // cnt_q holds beats already accepted, so the MAX_BEATS-th beat sees MAX_BEATS-1.
    assign trunc     = !in_last[grant_q] && (cnt_q == CW'(MAX_BEATS-1));
    assign beat_last = in_last[grant_q] || trunc;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            cnt_d = beat_last ? '0 : cnt_q + CW'(1);
            if (trunc) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_trunc = err_q;
`else
    assign beat_last = in_last[grant_q];
    assign err_trunc = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            out_data_d  = in_data[grant_q*DATA +: DATA];
            out_last_d  = beat_last;
            out_id_d    = IDB'(grant_q);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (scan_hit) begin
                    grant_d = scan_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && beat_last) begin
                    ptr_d   = ptr_inc;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_id    = out_id_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dlsc_pcie_tx_arbiter.sv
// tb/tb_dlsc_pcie_tx_arbiter.sv - self-checking bench for dlsc_pcie_tx_arbiter
module tb_dlsc_pcie_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IB = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [IB-1:0]     out_id;
    logic              out_valid;
    logic              out_ready;
    logic              err_trunc;

    always #5 clk = ~clk;

    dlsc_pcie_tx_arbiter #(
        .INPUTS(N), .DATA(DW), .IDB(IB), .MAX_BEATS(MB)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_id(out_id),
        .out_valid(out_valid), .out_ready(out_ready), .err_trunc(err_trunc)
    );

    typedef struct {
        int            cyc;
        int            id;
        logic [DW-1:0] d;
        logic          l;
    } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [DW:0] q [N][$];
    bit          rdy_q[$];
    ent_t        log_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                in_valid[i]          = 1'b1;
                in_data[i*DW +: DW]  = q[i][0][DW-1:0];
                in_last[i]           = q[i][0][DW];
            end else begin
                in_valid[i]          = 1'b0;
                in_data[i*DW +: DW]  = '0;
                in_last[i]           = 1'b0;
            end
        end
    endfunction

    task automatic push_pkt(input int i, input int base, input int len);
        for (int b = 0; b < len; b++) begin
            q[i].push_back({(b == len-1), DW'(base + b)});
        end
        drive();
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = in_valid & in_ready & {N{rst_n}};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(q[i].pop_front());
        end
        out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        drive();
        cyc++;
    endtask

    // Reference model: arbitration rules applied once per cycle on plain integers.
    bit            m_init = 0;
    bit            m_busy;
    int            m_grant, m_ptr, m_cnt, m_oid;
    bit            m_ov, m_ol, m_err;
    logic [DW-1:0] m_od;
    logic [N-1:0]  exp_rdy;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;

    initial begin
        int  g, idx;
        bit  acc, trunc, l;
        forever begin
            @(negedge clk);
            if (m_init) begin
                exp_rdy = '0;
                if (m_busy) exp_rdy[m_grant] = !m_ov || out_ready;
                check("in_ready",  in_ready,  exp_rdy);
                check("out_valid", out_valid, m_ov);
                check("out_data",  out_data,  m_od);
                check("out_last",  out_last,  m_ol);
                check("out_id",    out_id,    m_oid);
                check("err_trunc", err_trunc, m_err);
                if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
                if (prev_stall && rst_n) check("stall_data_stable", out_data, prev_data);
                if (out_valid && out_ready)
                    log_q.push_back('{cyc: cyc, id: int'(out_id), d: out_data, l: out_last});
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_data  = out_data;
            if (!rst_n) begin
                m_init = 1; m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0;
                m_ov = 0; m_od = '0; m_ol = 0; m_oid = 0; m_err = 0;
            end else if (m_init) begin
                if (m_busy) begin
                    g   = m_grant;
                    acc = in_valid[g] && (!m_ov || out_ready);
                    if (acc) begin
                        l     = in_last[g];
                        trunc = 0;
`ifdef DLSC_PCIE_ARB_MAXLEN_EN
                        trunc = !l && (m_cnt + 1 == MB);
`endif
                        m_ov  = 1;
                        m_od  = in_data[g*DW +: DW];
                        m_ol  = l || trunc;
                        m_oid = g;
                        if (l || trunc) begin
                            m_busy = 0;
                            m_ptr  = (g + 1) % N;
                            m_cnt  = 0;
                            if (trunc) m_err = 1;
                        end else begin
                            m_cnt++;
                        end
                    end else if (out_ready) begin
                        m_ov = 0;
                    end
                end else begin
                    if (out_ready) m_ov = 0;
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (!m_busy && in_valid[idx]) begin
                            m_busy  = 1;
                            m_grant = idx;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        drive();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_err",       err_trunc, 0);

        // Input 2, three beats, constant out_ready
        log_q.delete();
        n0 = cyc;
        push_pkt(2, 'hA0, 3);
        repeat (8) step();
        check("t1_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                check("t1_cycle", log_q[j].cyc, n0 + 2 + j);
                check("t1_id",    log_q[j].id,  2);
                check("t1_data",  log_q[j].d,   'hA0 + j);
                check("t1_last",  log_q[j].l,   j == 2);
            end
        end

        // ptr is now 3: input 3 wins over input 0
        log_q.delete();
        push_pkt(0, 'h10, 1);
        push_pkt(3, 'h13, 1);
        repeat (8) step();
        check("ptr3_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("ptr3_first",  log_q[0].id, 3);
            check("ptr3_second", log_q[1].id, 0);
        end

        // All inputs busy with single-beat packets after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        log_q.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push_pkt(i, 'h20 + i, 1);
        end
        repeat (20) step();
        check("rr_count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                check("rr_id", log_q[j].id, j % N);
                if (j > 0) check("rr_gap", log_q[j].cyc - log_q[j-1].cyc, 2);
            end
        end

        // Backpressure on a 4-beat packet from input 1
        log_q.delete();
        rdy_q = '{1, 0, 0, 1, 1, 0, 1};
        push_pkt(1, 'hB0, 4);
        repeat (14) step();
        check("bp_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                check("bp_data", log_q[j].d, 'hB0 + j);
                check("bp_id",   log_q[j].id, 1);
                check("bp_last", log_q[j].l, j == 3);
            end
        end

        // Input 3 waits for input 0's packet to finish
        log_q.delete();
        push_pkt(0, 'hD0, 3);
        step();
        step();
        push_pkt(3, 'hE0, 1);
        repeat (10) step();
        check("hold_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("hold_id0", log_q[2].id, 0);
            check("hold_id3", log_q[3].id, 3);
            check("hold_d3",  log_q[3].d,  'hE0);
            check("hold_gap", log_q[3].cyc - log_q[2].cyc, 2);
        end

        // Reset mid-packet
        push_pkt(2, 'hF0, 4);
        repeat (3) step();
        rst_n = 1'b0;
        push_pkt(1, 'h90, 1);
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data",  out_data,  0);
        check("mid_rst_last",  out_last,  0);
        check("mid_rst_id",    out_id,    0);
        rst_n = 1'b1;
        log_q.delete();
        repeat (12) step();
        check("mid_rst_nonempty", log_q.size() > 0, 1);
        if (log_q.size() > 0) begin
            check("mid_rst_first_id", log_q[0].id, 1);
            check("mid_rst_first_d",  log_q[0].d,  'h90);
        end

        // Overlong packet from input 1
        log_q.delete();
        push_pkt(1, 'hC0, 6);
        repeat (16) step();
        check("long_count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            for (int j = 0; j < 6; j++) check("long_data", log_q[j].d, 'hC0 + j);
`ifdef DLSC_PCIE_ARB_MAXLEN_EN
            for (int j = 0; j < 6; j++) check("long_last", log_q[j].l, (j == 3) || (j == 5));
            check("long_gap", log_q[4].cyc - log_q[3].cyc, 2);
`else
            for (int j = 0; j < 6; j++) check("long_last", log_q[j].l, j == 5);
`endif
        end
`ifdef DLSC_PCIE_ARB_MAXLEN_EN
        check("err_set", err_trunc, 1);
        repeat (3) step();
        check("err_sticky", err_trunc, 1);
`else
        check("err_zero", err_trunc, 0);
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("err_after_rst", err_trunc, 0);
        check("drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
